alu_execute_stage: RTL and testbench

//  Execute stage directly downstream of the instruction decoder. It consumes alu_control and

---
 rtl/alu_execute_stage.sv | 157 +++++++++++++++
 tb/tb_alu_execute_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage.sv
// alu_execute_stage
//   Execute stage fed by the instruction decoder. Single-cycle ALU ops
//   (AND/OR/ADD/SLL/SUB/SRL/XOR) are registered straight into the output
//   bundle. MUL runs on an iterative shift-add unit, one bit per cycle.
//   The result bundle leaves over a valid/ready handshake to writeback.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | accepting bundles; single-cycle results land in one edge
//   MUL_BUSY | shift-add multiply running; input side stalled
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     input handshake (in_ready has no in_valid path)
//   alu_control             operation select (see case table below)
//   regwrite_control        instruction writes rd
//   rs1_val, rs2_val        operands A and B
//   rd_addr                 destination register
//   out_valid / out_ready   output handshake
//   out_result, out_rd      registered result bundle, held under backpressure
//   out_regwrite            write enable, suppressed for x0
//   busy                    multiply in progress
module alu_execute_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic             regwrite_control,
   input  logic [WIDTH-1:0] rs1_val,
   input  logic [WIDTH-1:0] rs2_val,
   input  logic [4:0]       rd_addr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [4:0]       out_rd,
   output logic             out_regwrite,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;

   typedef enum logic {
      IDLE,
      MUL_BUSY
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_acc;
   logic [CW-1:0]    mul_cnt;
   logic [4:0]       mul_rd;
   logic             mul_regwrite;

   logic             accept;
   logic             pop;
   logic             op_known;
   logic             wr_en;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] acc_next;

   assign in_ready = (state == IDLE) & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign wr_en    = regwrite_control & (rd_addr != 5'd0) & op_known;
   assign acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

   always_comb begin
      alu_res  = '0;
      op_known = 1'b1;
      unique case (alu_control)
         OP_AND:  alu_res = rs1_val & rs2_val;
         OP_OR:   alu_res = rs1_val | rs2_val;
         OP_ADD:  alu_res = rs1_val + rs2_val;
         OP_SLL:  alu_res = rs1_val << rs2_val[SHW-1:0];
         OP_SUB:  alu_res = rs1_val - rs2_val;
         OP_SRL:  alu_res = rs1_val >> rs2_val[SHW-1:0];
         OP_MUL:  alu_res = '0;
         OP_XOR:  alu_res = rs1_val ^ rs2_val;
         default: op_known = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd       <= '0;
         out_regwrite <= 1'b0;
         busy         <= 1'b0;
         mul_a        <= '0;
         mul_b        <= '0;
         mul_acc      <= '0;
         mul_cnt      <= '0;
         mul_rd       <= '0;
         mul_regwrite <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  out_valid <= 1'b0;
               end
               if (accept) begin
                  if (alu_control == OP_MUL) begin
                     // out_valid is already low or being popped here, since
                     // accept implies ~out_valid | out_ready.
                     mul_a        <= rs1_val;
                     mul_b        <= rs2_val;
                     mul_acc      <= '0;
                     mul_cnt      <= CW'(WIDTH);
                     mul_rd       <= rd_addr;
                     mul_regwrite <= wr_en;
                     busy         <= 1'b1;
                     state        <= MUL_BUSY;
                  end else begin
                     out_result   <= alu_res;
                     out_rd       <= rd_addr;
                     out_regwrite <= wr_en;
                     out_valid    <= 1'b1;
                  end
               end
            end
            MUL_BUSY: begin
               mul_acc <= acc_next;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               mul_cnt <= mul_cnt - CW'(1);
               // Last step folds its own partial product into the result.
               if (mul_cnt == CW'(1)) begin
                  out_result   <= acc_next;
                  out_rd       <= mul_rd;
                  out_regwrite <= mul_regwrite;
                  out_valid    <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_execute_stage.sv
module tb_alu_execute_stage;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_control;
   logic             regwrite_control;
   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;
   logic [4:0]       rd_addr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [4:0]       out_rd;
   logic             out_regwrite;
   logic             busy;

   alu_execute_stage #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .regwrite_control(regwrite_control),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd),
      .out_regwrite(out_regwrite), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Transaction-level reference: the bundle sitting at the output, plus a
   // pending multiply result and the number of edges until it appears.
   bit               exp_ov;
   logic [WIDTH-1:0] exp_res;
   logic [4:0]       exp_rd;
   bit               exp_rw;
   int               mul_left;
   logic [WIDTH-1:0] pend_res;
   logic [4:0]       pend_rd;
   bit               pend_rw;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      longint unsigned prod;
      int sh;
      sh = int'(b % WIDTH);
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a << sh;
         4'd4: return a - b;
         4'd5: return a >> sh;
         4'd6: begin
            prod = longint'(a) * longint'(b);
            return prod[WIDTH-1:0];
         end
         4'd7: return a ^ b;
         default: return '0;
      endcase
   endfunction

   function automatic bit ref_rw(input logic [3:0] op, input bit rw, input logic [4:0] rd);
      return (op <= 4'd7) && rw && (rd != 5'd0);
   endfunction

   task automatic model_reset();
      exp_ov   = 0;
      mul_left = 0;
   endtask

   // Compare every output against the model at the falling edge, predict the
   // effect of the coming rising edge, then return just after that edge.
   task automatic tick();
      bit exp_ir;
      @(negedge clk);
      exp_ir = (mul_left == 0) && (!exp_ov || out_ready);
      check("in_ready", in_ready, exp_ir);
      check("out_valid", out_valid, exp_ov);
      check("busy", busy, mul_left != 0);
      if (exp_ov) begin
         check("out_result", out_result, exp_res);
         check("out_rd", out_rd, exp_rd);
         check("out_regwrite", out_regwrite, exp_rw);
      end
      if (mul_left != 0) begin
         mul_left--;
         if (mul_left == 0) begin
            exp_ov  = 1;
            exp_res = pend_res;
            exp_rd  = pend_rd;
            exp_rw  = pend_rw;
         end
      end else begin
         if (exp_ov && out_ready) exp_ov = 0;
         if (in_valid && exp_ir) begin
            if (alu_control == 4'd6) begin
               mul_left = WIDTH;
               pend_res = ref_alu(alu_control, rs1_val, rs2_val);
               pend_rd  = rd_addr;
               pend_rw  = ref_rw(alu_control, regwrite_control, rd_addr);
            end else begin
               exp_ov  = 1;
               exp_res = ref_alu(alu_control, rs1_val, rs2_val);
               exp_rd  = rd_addr;
               exp_rw  = ref_rw(alu_control, regwrite_control, rd_addr);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [4:0] rd, input bit rw);
      in_valid         = v;
      alu_control      = op;
      rs1_val          = a;
      rs2_val          = b;
      rd_addr          = rd;
      regwrite_control = rw;
   endtask

   task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] want, input string tag);
      drive(1, 4'd6, a, b, 5'd9, 1);
      tick();
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      for (int i = 0; i < WIDTH; i++) tick();
      check({tag, "_valid"}, out_valid, 1);
      check(tag, out_result, want);
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      model_reset();
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_regwrite", out_regwrite, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // ADD 5+7 -> 12 one cycle later
      drive(1, 4'd2, 5, 7, 5'd3, 1);
      tick();
      check("add_valid", out_valid, 1);
      check("add_result", out_result, 12);
      check("add_rd", out_rd, 3);
      check("add_rw", out_regwrite, 1);
      drive(1, 4'd4, 3, 5, 5'd4, 1);
      tick();
      check("sub_result", out_result, 32'hFFFF_FFFE);
      drive(1, 4'd3, 1, 33, 5'd5, 1);
      tick();
      check("sll_result", out_result, 2);
      drive(1, 4'd7, 32'hF0, 32'hFF, 5'd6, 1);
      tick();
      check("xor_result", out_result, 32'h0F);
      drive(1, 4'd5, 32'h8000_0000, 31, 5'd6, 1);
      tick();
      check("srl_result", out_result, 1);
      drive(1, 4'd2, 10, 20, 5'd0, 1);
      tick();
      check("x0_regwrite", out_regwrite, 0);
      drive(1, 4'hF, 10, 20, 5'd7, 1);
      tick();
      check("bad_op_valid", out_valid, 1);
      check("bad_op_result", out_result, 0);
      check("bad_op_rw", out_regwrite, 0);
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      tick();

      run_mul(7, 6, 42, "mul_7x6");
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mul_ff");
      run_mul(32'h0001_0000, 32'h0001_0000, 0, "mul_ovf");

      // backpressure: hold result for 5 cycles, then pop+push back to back
      drive(1, 4'd2, 100, 23, 5'd8, 1);
      tick();
      out_ready = 1'b0;
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      for (int i = 0; i < 5; i++) tick();
      check("bp_hold", out_result, 123);
      check("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      drive(1, 4'd2, 1, 2, 5'd10, 1);
      tick();
      check("b2b_add", out_result, 3);
      drive(1, 4'd1, 32'hA0, 32'h0B, 5'd11, 1);
      tick();
      check("b2b_or", out_result, 32'hAB);
      check("b2b_or_rd", out_rd, 11);
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      tick();

      // reset in the middle of a multiply
      drive(1, 4'd6, 3, 4, 5'd2, 1);
      tick();
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      for (int i = 0; i < 9; i++) tick();
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", out_valid, 0);
      check("mrst_busy", busy, 0);
      #2;
      rst_n = 1'b1;
      model_reset();
      drive(1, 4'd2, 1, 1, 5'd1, 1);
      tick();
      check("post_rst_add", out_result, 2);
      check("post_rst_valid", out_valid, 1);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 9) == 0) ? 4'd6 : 4'($urandom_range(0, 15));
         if (op == 4'd6 && $urandom_range(0, 2) != 0) op = 4'd2;
         drive($urandom_range(0, 9) < 7, op, $urandom, $urandom, 5'($urandom_range(0, 31)),
               $urandom_range(0, 1) == 1);
         out_ready = $urandom_range(0, 9) < 6;
         tick();
      end
      drive(0, 4'd0, 0, 0, 5'd0, 0);
      out_ready = 1'b1;
      for (int i = 0; i < WIDTH + 2; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
